act_spd_scan_ctrl: RTL

Refresh controller that time-multiplexes the action digit and the speed digit onto one shared 7-segment bus. It produces the select that steers the action/speed 2:1 segment multiplexer, plus the per-digit enables.
- Inserts a blanking gap at each digit change to prevent ghosting.
- Latches the action and speed codes only at frame boundaries, so a digit never tears mid-frame.
- Sits between the toy-dog control logic and the segment multiplexer / display pins.

---
 rtl/act_spd_pkg.sv | 37 +++
 rtl/scan_slot_counter.sv | 40 ++++
 rtl/act_spd_scan_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/act_spd_pkg.sv
// act_spd_pkg: shared definitions for the action/speed display scanner.
//   - scan_state_e : scanner state encoding
//   - DIG_*        : digit index within digit_en_n
//   - EN_*         : active-low digit-enable patterns
//   - sel_of/en_of : per-state mux select and digit-enable pattern
package act_spd_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BLANK_ACT = 3'd1,
        SHOW_ACT  = 3'd2,
        BLANK_SPD = 3'd3,
        SHOW_SPD  = 3'd4
    } scan_state_e;

    localparam int DIG_ACT = 0;
    localparam int DIG_SPD = 1;

    localparam logic [1:0] EN_NONE = 2'b11;
    localparam logic [1:0] EN_ACT  = 2'b10;
    localparam logic [1:0] EN_SPD  = 2'b01;

    // Speed segments are steered onto the bus for both speed states,
    // so the mux never switches while a digit is lit (except BLANK=0).
    function automatic logic sel_of(scan_state_e s);
        return (s == BLANK_SPD) || (s == SHOW_SPD);
    endfunction

    function automatic logic [1:0] en_of(scan_state_e s);
        case (s)
            SHOW_ACT: return EN_ACT;
            SHOW_SPD: return EN_SPD;
            default:  return EN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// scan_slot_counter: slot timer for the display scanner.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : synchronous clear (wins over increment)
//   inc_i      : count enable
//   term_i     : terminal value to compare against
//   hit_o      : count equals term_i
module scan_slot_counter #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [CW-1:0] term_i,
    output logic          hit_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/act_spd_scan_ctrl.sv
// act_spd_scan_ctrl: time-multiplexes the action and speed digits onto one
// shared 7-segment bus, with a blanking gap before each digit is lit.
//   clk, reset  : clock, synchronous active-high reset
//   enable      : 1 = scan, 0 = display off and scanner parked in IDLE
//   act_code    : action code, captured only at frame boundaries
//   spd_code    : speed code, captured only at frame boundaries
//   act_q/spd_q : captured codes for the digit decoders
//   sel         : segment mux select, 0 = action, 1 = speed
//   digit_en_n  : active-low digit enables, [0] action, [1] speed
//   frame_tick  : one-cycle pulse on the first cycle of each frame
module act_spd_scan_ctrl
    import act_spd_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 5000,
    parameter int CW    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] act_code,
    input  logic [1:0] spd_code,
    output logic [2:0] act_q,
    output logic [1:0] spd_q,
    output logic       sel,
    output logic [1:0] digit_en_n,
    output logic       frame_tick
);

    // With no blank time the blank states are bypassed entirely.
    localparam scan_state_e FIRST_ACT = (BLANK == 0) ? SHOW_ACT : BLANK_ACT;
    localparam scan_state_e FIRST_SPD = (BLANK == 0) ? SHOW_SPD : BLANK_SPD;

    localparam logic [CW-1:0] SHOW_TERM  = CW'(DIV - BLANK - 1);
    localparam logic [CW-1:0] BLANK_TERM = CW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_e   state_q;
    scan_state_e   state_d;
    logic [CW-1:0] term;
    logic          hit;
    logic          boundary;

    always_comb begin
        term = SHOW_TERM;
        if (state_q == BLANK_ACT || state_q == BLANK_SPD) begin
            term = BLANK_TERM;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = FIRST_ACT;
            BLANK_ACT: if (hit) state_d = SHOW_ACT;
            SHOW_ACT:  if (hit) state_d = FIRST_SPD;
            BLANK_SPD: if (hit) state_d = SHOW_SPD;
            SHOW_SPD:  if (hit) state_d = FIRST_ACT;
            default:   state_d = IDLE;
        endcase
        // Dropping enable overrides every transition, including a boundary.
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // A frame starts whenever the first action state is newly entered.
    assign boundary = (state_d == FIRST_ACT) && (state_q != FIRST_ACT);

    scan_slot_counter #(
        .CW(CW)
    ) u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_d != state_q),
        .inc_i (state_q != IDLE),
        .term_i(term),
        .hit_o (hit)
    );

    // Outputs are derived from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel        <= 1'b0;
            digit_en_n <= EN_NONE;
            frame_tick <= 1'b0;
            act_q      <= 3'b000;
            spd_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            sel        <= sel_of(state_d);
            digit_en_n <= en_of(state_d);
            frame_tick <= boundary;
            if (boundary) begin
                act_q <= act_code;
                spd_q <= spd_code;
            end
        end
    end

endmodule
